pwm_core: RTL and testbench
===========================

Name: pwm_core

Overview:
- MMIO slot core for slot 5 (S5_PWM) of the vanilla MMIO subsystem.
- Driven directly by the MMIO controller's per-slot signals: cs, read, write, addr, wr_data, rd_data.
- Generates W independent PWM outputs, all sharing one prescaler and one period counter, for LED dimming and external drivers.
- Duty registers are double-buffered, so a new duty value takes effect only at a period boundary.

Parameters:
- W, 6, number of PWM channels (1..16).
- R, 8, duty resolution in bits; the period is 2^R steps.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot select from the MMIO controller.
- read  in  1  read strobe, valid with cs.
- write  in  1  write strobe, valid with cs.
- addr  in  5  slot register address.
- wr_data  in  32  write data.
- rd_data  out  32  read data; combinational from addr.
- pwm_out  out  W  PWM outputs, registered.

Behaviour:
- One clock domain. Reset is synchronous and active-high; port names are clk and reset.
- Register map. A write takes effect when cs && write at the clock edge.
  - addr 0x00 DVSR: 32 bits, read/write, reset 0.
  - addr 0x01 CTRL: bit0 = enable, read/write, reset 0. Bits 31:1 read as 0.
  - addr 0x02 STATUS: read-only. Bits R-1:0 = current period counter d_reg. Other bits read 0.
  - addr 0x10+i, i<W, DUTY_i: write stores wr_data[R:0] into pend_i (R+1 bits, reset 0). Reads return pend_i zero-extended.
  - Writes to all other addresses are ignored. Reads of all other addresses return 0.
- rd_data is a pure mux on addr, independent of cs/read, with zero wait states. read has no side effects.
- Prescaler q_reg (32 bits):
  - When enabled: if q_reg == DVSR, tick = 1 and q_reg <= 0; otherwise q_reg <= q_reg + 1.
  - DVSR = 0 gives a tick every cycle.
  - DVSR = 0xFFFFFFFF is legal and gives a tick every 2^32 cycles.
- Period counter d_reg (R bits):
  - Increments on tick and wraps from 2^R-1 to 0.
  - Period = (DVSR+1) * 2^R clocks.
- Duty shadowing, for each channel: act_i <= pend_i when (enable && tick && d_reg == 2^R-1), i.e. on the wrap to 0. It also loads when enable is 0, so duties written while disabled apply at the first period.
- Output: pwm_out[i] <= enable && (d_reg < act_i), compared as (R+1)-bit unsigned. Output therefore lags counter state by one clock.
  - act_i = 0 gives constant 0.
  - act_i >= 2^R gives constant 1 (100% duty).
  - Values above 2^R behave as 2^R.
- Disable: writing enable = 0 forces q_reg = 0 and d_reg = 0 next cycle. pwm_out goes to 0 one cycle after that. Re-enable starts a fresh period at d_reg = 0.
- DVSR write while enabled: q_reg is not cleared.
  - If q_reg > new DVSR, q_reg runs up to 0xFFFFFFFF and wraps to 0 without a tick, then resumes the normal sequence.
  - Software clears enable around DVSR changes.
- Simultaneous write and wrap: if a DUTY_i write and the wrap load fall on the same edge, act_i takes the OLD pend_i. The new value applies at the next wrap.
- Reset mid-operation: clears DVSR, CTRL, all pend_i/act_i, q_reg and d_reg. pwm_out = 0 from the cycle after the reset edge.
- Reset values: rd_data = 0 for addresses 0x00–0x02 and for every DUTY_i (all registers 0); pwm_out = 0.

Test Plan:
- Basic duty, W=6, R=8: reset; DVSR=0; DUTY_0=64; enable=1. Each 256-cycle period shows pwm_out[0] high 64 cycles and low 192. The rising edge occurs one cycle after d_reg becomes 0.
- Extremes: DUTY_1=0 gives pwm_out[1] constantly 0. DUTY_2=256 gives constantly 1. DUTY_3=300 gives constantly 1. DUTY_4=255 gives 255 high, 1 low per period.
- Prescaler: DVSR=3, DUTY_0=128. Period = 1024 clocks, high 512. STATUS increments every 4 clocks.
- Shadow timing: with DUTY_0=64 running, write DUTY_0=192 at d_reg=100. The current period still ends high-time at count 64. The next period is high for 192 steps. A readback of DUTY_0 returns 192 immediately.
- Write/wrap collision: issue the DUTY_0 write on exactly the edge where d_reg=255 and tick=1. The old duty holds for one more period, then the new duty applies.
- Disable/reset mid-period: enable=0 at d_reg=50 gives STATUS=0 next cycle and pwm_out=0 the cycle after. Synchronous reset pulse mid-period gives all registers reading 0 and pwm_out=0.
- Unmapped addresses: read of 0x05 or 0x1F returns 0.

Source files
------------

// File: rtl/pwm_core_if.sv
// MMIO slot bus seen by a single core: select, strobes, address and data.
// The controller drives the request side; the core returns rd_data.
interface pwm_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/pwm_core.sv
// W-channel PWM slot core: shared prescaler and period counter,
// double-buffered duty registers that switch over on the period wrap.
module pwm_core #(
    parameter int W = 6,
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    pwm_core_if.slave    bus,
    output logic [W-1:0] pwm_out
);

    localparam logic [R-1:0] D_MAX = '1;
    localparam logic [R-1:0] D_ONE = R'(1);

    logic [31:0]  dvsr_reg;
    logic         en_reg;
    logic [31:0]  q_reg;
    logic [R-1:0] d_reg;
    logic [R:0]   pend [W];
    logic [R:0]   act  [W];

    logic         wr_en;
    logic         ctrl_wr;
    logic         run;
    logic         tick;
    logic         wrap;
    logic [W-1:0] duty_hit;
    logic [31:0]  duty_rd;
    logic         unused_read;

    assign unused_read = bus.read;

    assign wr_en   = bus.cs && bus.write;
    assign ctrl_wr = wr_en && (bus.addr == 5'h01);
    // A disabling write clears the counters on the same edge it lands.
    assign run     = en_reg && !(ctrl_wr && !bus.wr_data[0]);
    assign tick    = run && (q_reg == dvsr_reg);
    assign wrap    = tick && (d_reg == D_MAX);

    always_comb begin
        duty_hit = '0;
        duty_rd  = '0;
        for (int i = 0; i < W; i++) begin
            if (bus.addr == 5'(16 + i)) begin
                duty_hit[i] = 1'b1;
                duty_rd     = 32'(pend[i]);
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        unique case (1'b1)
            (bus.addr == 5'h00): bus.rd_data = dvsr_reg;
            (bus.addr == 5'h01): bus.rd_data = {31'b0, en_reg};
            (bus.addr == 5'h02): bus.rd_data = 32'(d_reg);
            (|duty_hit):         bus.rd_data = duty_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_reg <= '0;
            en_reg   <= 1'b0;
            q_reg    <= '0;
            d_reg    <= '0;
            pwm_out  <= '0;
            for (int i = 0; i < W; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            if (wr_en && (bus.addr == 5'h00))
                dvsr_reg <= bus.wr_data;
            if (ctrl_wr)
                en_reg <= bus.wr_data[0];

            if (!run) begin
                q_reg <= '0;
                d_reg <= '0;
            end else if (tick) begin
                q_reg <= '0;
                d_reg <= d_reg + D_ONE;
            end else begin
                q_reg <= q_reg + 32'd1;
            end

            // Shadow follows pend while idle so the first period
            // after enable already uses the programmed duty.
            for (int i = 0; i < W; i++) begin
                if (wr_en && duty_hit[i])
                    pend[i] <= bus.wr_data[R:0];
                if (!en_reg || wrap)
                    act[i] <= pend[i];
                pwm_out[i] <= en_reg && ({1'b0, d_reg} < act[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// Randomized bench for pwm_core against a time-based reference model.
// The model derives the counter from elapsed enabled cycles.
module tb_pwm_core;

    localparam int    W     = 6;
    localparam int    R     = 8;
    localparam longint STEPS = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pwm_out;

    pwm_core_if bus ();

    pwm_core #(.W(W), .R(R)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    longint       m_dvsr;
    longint       m_t;
    bit           m_en;
    int           m_pend [W];
    int           m_act  [W];
    logic [W-1:0] m_pwm;
    int           hi [W];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_d();
        if (!m_en) return 0;
        return int'((m_t / (m_dvsr + 1)) % STEPS);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return m_dvsr[31:0];
        if (ai == 1) return {31'b0, m_en};
        if (ai == 2) return 32'(m_d());
        if (ai >= 16 && ai < 16 + W) return 32'(m_pend[ai - 16]);
        return 32'h0;
    endfunction

    task automatic step();
        int  d0;
        bit  wr;
        bit  dis;
        bit  run;
        bit  wrap;
        int  ai;
        @(posedge clk);
        if (reset) begin
            m_dvsr = 0;
            m_en   = 0;
            m_t    = 0;
            m_pwm  = '0;
            for (int i = 0; i < W; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
        end else begin
            d0 = m_d();
            wr = bus.cs && bus.write;
            ai = int'(bus.addr);
            for (int i = 0; i < W; i++)
                m_pwm[i] = m_en && (d0 < m_act[i]);
            dis  = wr && ai == 1 && !bus.wr_data[0];
            run  = m_en && !dis;
            wrap = run && ((m_t + 1) % ((m_dvsr + 1) * STEPS) == 0);
            if (!m_en || wrap) m_act = m_pend;
            m_t = run ? m_t + 1 : 0;
            if (wr) begin
                if (ai == 0) m_dvsr = longint'(bus.wr_data);
                if (ai == 1) m_en = bus.wr_data[0];
                if (ai >= 16 && ai < 16 + W)
                    m_pend[ai - 16] = int'(bus.wr_data[R:0]);
            end
        end
        #1;
        chk("pwm", 32'(pwm_out), 32'(m_pwm));
        chk("rd", bus.rd_data, m_rd(bus.addr));
        for (int i = 0; i < W; i++)
            if (pwm_out[i]) hi[i]++;
    endtask

    task automatic idle();
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'($urandom_range(0, 1));
        bus.wr_data = $urandom;
        case ($urandom_range(0, 5))
            0: bus.addr = 5'h00;
            1: bus.addr = 5'h01;
            2: bus.addr = 5'h02;
            3: bus.addr = 5'(16 + $urandom_range(0, W - 1));
            4: bus.addr = 5'h05;
            default: bus.addr = 5'h1F;
        endcase
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.read    = 1'b0;
        bus.addr    = a;
        bus.wr_data = d;
        step();
        bus.cs    = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        bus.cs    = 1'b1;
        bus.read  = 1'b1;
        bus.write = 1'b0;
        bus.addr  = a;
        step();
        chk(tag, bus.rd_data, exp);
        bus.cs   = 1'b0;
        bus.read = 1'b0;
    endtask

    task automatic run_n(input int n);
        repeat (n) begin
            idle();
            step();
        end
    endtask

    task automatic run_until_d(input int v);
        int g;
        g = 0;
        while (m_d() != v && g < 3000) begin
            idle();
            step();
            g++;
        end
        chk("wait_d", 32'(g < 3000), 32'd1);
    endtask

    task automatic clr_hi();
        for (int i = 0; i < W; i++) hi[i] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        rd_chk("rst_dvsr", 5'h00, 32'h0);
        rd_chk("rst_ctrl", 5'h01, 32'h0);
        rd_chk("rst_stat", 5'h02, 32'h0);
        for (int i = 0; i < W; i++)
            rd_chk("rst_duty", 5'(16 + i), 32'h0);
        chk("rst_pwm", 32'(pwm_out), 32'h0);

        rd_chk("unmap_05", 5'h05, 32'h0);
        rd_chk("unmap_1f", 5'h1F, 32'h0);
        wr(5'h05, 32'hFFFF_FFFF);
        rd_chk("unmap_wr", 5'h05, 32'h0);

        // basic duty plus extremes
        wr(5'h00, 32'd0);
        wr(5'h10, 32'd64);
        wr(5'h11, 32'd0);
        wr(5'h12, 32'd256);
        wr(5'h13, 32'd300);
        wr(5'h14, 32'd255);
        wr(5'h15, $urandom);
        wr(5'h01, 32'd1);
        chk("pre_rise", 32'(pwm_out[0]), 32'd0);
        clr_hi();
        run_n(1);
        chk("rise", 32'(pwm_out[0]), 32'd1);
        run_n(511);
        chk("hi_d64", hi[0], 32'd128);
        chk("hi_d0", hi[1], 32'd0);
        chk("hi_d256", hi[2], 32'd512);
        chk("hi_d300", hi[3], 32'd512);
        chk("hi_d255", hi[4], 32'd510);

        // shadow timing
        run_until_d(0);
        clr_hi();
        run_until_d(100);
        wr(5'h10, 32'd192);
        chk("shadow_rdback", bus.rd_data, 32'd192);
        run_until_d(0);
        chk("shadow_cur", hi[0], 32'd64);
        clr_hi();
        run_n(256);
        chk("shadow_next", hi[0], 32'd192);

        // write lands on the wrap edge
        run_until_d(255);
        wr(5'h10, 32'd32);
        clr_hi();
        run_n(256);
        chk("coll_old", hi[0], 32'd192);
        clr_hi();
        run_n(256);
        chk("coll_new", hi[0], 32'd32);

        // disable mid-period
        run_until_d(50);
        wr(5'h01, 32'd0);
        bus.addr = 5'h02;
        #1;
        chk("dis_status", bus.rd_data, 32'h0);
        chk("dis_lag", 32'(pwm_out[2]), 32'd1);
        run_n(1);
        chk("dis_pwm", 32'(pwm_out), 32'h0);

        // prescaler
        wr(5'h00, 32'd3);
        wr(5'h10, 32'd128);
        wr(5'h01, 32'd1);
        clr_hi();
        run_n(1024);
        chk("presc_hi", hi[0], 32'd512);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            wr(5'h01, 32'd0);
            wr(5'h00, 32'($urandom_range(0, 2)));
            for (int i = 0; i < W; i++)
                wr(5'(16 + i), $urandom);
            wr(5'h01, $urandom | 32'd1);
            repeat (1000) begin
                if ($urandom_range(0, 19) == 0) begin
                    bus.cs      = 1'b1;
                    bus.write   = 1'b1;
                    bus.addr    = 5'(16 + $urandom_range(0, W - 1));
                    bus.wr_data = $urandom;
                end else if ($urandom_range(0, 49) == 0) begin
                    bus.cs      = 1'b1;
                    bus.write   = 1'b1;
                    bus.addr    = 5'($urandom_range(3, 15));
                    bus.wr_data = $urandom;
                end else begin
                    idle();
                end
                step();
            end
        end

        // reset pulse mid-period
        run_n(37);
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_pwm", 32'(pwm_out), 32'h0);
        rd_chk("mrst_dvsr", 5'h00, 32'h0);
        rd_chk("mrst_ctrl", 5'h01, 32'h0);
        rd_chk("mrst_stat", 5'h02, 32'h0);
        for (int i = 0; i < W; i++)
            rd_chk("mrst_duty", 5'(16 + i), 32'h0);
        chk("mrst_pwm2", 32'(pwm_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
